// File: rtl/beam_threshold_sequencer.sv
// Shadows both threshold sets of every beam and streams them pair-by-pair into the DSP cascade
// on commit, then strobes update. Optional readback port: define THRESH_READBACK_EN.
module beam_threshold_sequencer #(
  parameter int unsigned NBEAMS         = 46,
  parameter int unsigned UPDATE_GAP     = 2,
  parameter logic [17:0] THRESH_DEFAULT = 18'h3FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        wr_set_i,
  input  logic [5:0]  wr_beam_i,
  input  logic [17:0] wr_data_i,
  input  logic        commit_i,
  input  logic [1:0]  commit_mask_i,
  output logic [35:0] thresh_o,
  output logic [1:0]  thresh_wr_o,
  output logic [1:0]  thresh_update_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        wr_drop_o
`ifdef THRESH_READBACK_EN
  ,
  input  logic        rd_i,
  input  logic        rd_set_i,
  input  logic [5:0]  rd_beam_i,
  output logic [17:0] rd_data_o
`endif
);

  localparam int unsigned NPAIRS = (NBEAMS + 1) / 2;
  localparam int unsigned CW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int unsigned GW     = (UPDATE_GAP > 1) ? $clog2(UPDATE_GAP) : 1;
  localparam int unsigned BW     = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StGap, StUpdate, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            set_q, set_d;
  logic [1:0]      mask_q, mask_d;
  logic [1:0]      pend_q, pend_d;
  logic            drop_q, drop_d;
  logic [35:0]     thresh_q, thresh_d;
  logic [17:0]     shadow_q [2][NBEAMS];

  logic            busy, commit_ok, shadow_we, start, load_pair, b_valid;
  logic [1:0]      set_oh, start_mask, remaining, effective;
  logic [BW-1:0]   a_idx, b_idx;

  assign busy      = (state_q != StIdle);
  assign commit_ok = commit_i && (commit_mask_i != 2'b00);
  assign shadow_we = wr_i && !busy && (32'(wr_beam_i) < NBEAMS);
  assign set_oh    = set_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '{default: THRESH_DEFAULT};
    end else if (shadow_we) begin
      shadow_q[wr_set_i][wr_beam_i[BW-1:0]] <= wr_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    set_d      = set_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    start      = 1'b0;
    start_mask = 2'b00;
    load_pair  = 1'b0;
    remaining  = mask_q & ~set_oh;
    // A commit arriving in the DONE cycle must not slip past the pending check.
    effective  = pend_q | (commit_ok ? commit_mask_i : 2'b00);

    if (busy && commit_ok) pend_d = pend_q | commit_mask_i;
    if (commit_ok) drop_d = 1'b0;
    if (wr_i && busy) drop_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (commit_ok) begin
          start      = 1'b1;
          start_mask = commit_mask_i;
        end
      end
      StLoad: begin
        if (cnt_q == '0) begin
          if (UPDATE_GAP == 0) begin
            state_d = StUpdate;
          end else begin
            state_d = StGap;
            gap_d   = GW'(UPDATE_GAP - 1);
          end
        end else begin
          cnt_d     = cnt_q - CW'(1);
          load_pair = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StUpdate;
        else gap_d = gap_q - GW'(1);
      end
      StUpdate: begin
        mask_d = remaining;
        if (remaining != 2'b00) begin
          start      = 1'b1;
          start_mask = remaining;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (effective != 2'b00) begin
          start      = 1'b1;
          start_mask = effective;
          pend_d     = 2'b00;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d   = StLoad;
      mask_d    = start_mask;
      set_d     = ~start_mask[0];
      cnt_d     = CW'(NPAIRS - 1);
      load_pair = 1'b1;
    end
  end

  // Pair word for the cycle being entered; odd NBEAMS pads the missing B beam.
  always_comb begin
    a_idx    = BW'({cnt_d, 1'b0});
    b_valid  = (32'({cnt_d, 1'b1}) < NBEAMS);
    b_idx    = b_valid ? BW'({cnt_d, 1'b1}) : a_idx;
    thresh_d = thresh_q;
    if (load_pair) begin
      thresh_d = {(b_valid ? shadow_q[set_d][b_idx] : THRESH_DEFAULT), shadow_q[set_d][a_idx]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      gap_q    <= '0;
      set_q    <= 1'b0;
      mask_q   <= 2'b00;
      pend_q   <= 2'b00;
      drop_q   <= 1'b0;
      thresh_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      set_q    <= set_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      thresh_q <= thresh_d;
    end
  end

  always_comb begin
    thresh_o        = thresh_q;
    thresh_wr_o     = 2'b00;
    thresh_update_o = 2'b00;
    busy_o          = busy;
    done_o          = (state_q == StDone);
    wr_drop_o       = drop_q;
    if (state_q == StLoad) thresh_wr_o = set_oh;
    if (state_q == StUpdate) thresh_update_o = set_oh;
  end

`ifdef THRESH_READBACK_EN
  logic [17:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_i) begin
      rd_data_d = (32'(rd_beam_i) < NBEAMS) ? shadow_q[rd_set_i][rd_beam_i[BW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_beam_threshold_sequencer.sv
// Directed bench: 46-beam instance for the main flows, 45-beam instance for odd padding and
// mid-load reset. Both instances share stimulus.
module tb_beam_threshold_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_i = 1'b0, wr_set_i = 1'b0;
  logic [5:0]  wr_beam_i = '0;
  logic [17:0] wr_data_i = '0;
  logic        commit_i = 1'b0;
  logic [1:0]  commit_mask_i = '0;

  logic [35:0] th, th45;
  logic [1:0]  twr, twr45, tup, tup45;
  logic        busy, busy45, done, done45, drop, drop45;
`ifdef THRESH_READBACK_EN
  logic        rd_i = 1'b0, rd_set_i = 1'b0;
  logic [5:0]  rd_beam_i = '0;
  logic [17:0] rd_data, rd_data45;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0]  cap_wr [0:63], cap_up [0:63], c45_wr [0:63], c45_up [0:63];
  logic [35:0] cap_th [0:63], c45_th [0:63];
  logic        cap_done [0:63], cap_busy [0:63], cap_drop [0:63], c45_done [0:63];

  always #5 clk = ~clk;

  beam_threshold_sequencer #(.NBEAMS(46), .UPDATE_GAP(2), .THRESH_DEFAULT(18'h3FFFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .wr_set_i(wr_set_i), .wr_beam_i(wr_beam_i),
    .wr_data_i(wr_data_i), .commit_i(commit_i), .commit_mask_i(commit_mask_i),
    .thresh_o(th), .thresh_wr_o(twr), .thresh_update_o(tup), .busy_o(busy), .done_o(done),
    .wr_drop_o(drop)
`ifdef THRESH_READBACK_EN
    , .rd_i(rd_i), .rd_set_i(rd_set_i), .rd_beam_i(rd_beam_i), .rd_data_o(rd_data)
`endif
  );

  beam_threshold_sequencer #(.NBEAMS(45), .UPDATE_GAP(2), .THRESH_DEFAULT(18'h3FFFF)) dut45 (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .wr_set_i(wr_set_i), .wr_beam_i(wr_beam_i),
    .wr_data_i(wr_data_i), .commit_i(commit_i), .commit_mask_i(commit_mask_i),
    .thresh_o(th45), .thresh_wr_o(twr45), .thresh_update_o(tup45), .busy_o(busy45),
    .done_o(done45), .wr_drop_o(drop45)
`ifdef THRESH_READBACK_EN
    , .rd_i(rd_i), .rd_set_i(rd_set_i), .rd_beam_i(rd_beam_i), .rd_data_o(rd_data45)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_shadow(input logic set, input int beam, input int val);
    wr_i = 1'b1; wr_set_i = set; wr_beam_i = 6'(beam); wr_data_i = 18'(val);
    tick();
    wr_i = 1'b0;
  endtask

  // Commit m0 in cycle 0, sample cycles 1..n; optional second commit / busy write in later cycles.
  task automatic capture(input int n, input logic [1:0] m0, input int c2, input logic [1:0] m2,
                         input int wcyc);
    commit_i = 1'b1; commit_mask_i = m0;
    for (int i = 1; i <= n; i++) begin
      tick();
      cap_wr[i] = twr; cap_up[i] = tup; cap_th[i] = th; cap_done[i] = done;
      cap_busy[i] = busy; cap_drop[i] = drop;
      c45_wr[i] = twr45; c45_up[i] = tup45; c45_th[i] = th45; c45_done[i] = done45;
      commit_i = (i == c2); commit_mask_i = (i == c2) ? m2 : 2'b00;
      wr_i = (i == wcyc); wr_set_i = 1'b0; wr_beam_i = 6'd0; wr_data_i = 18'h07777;
    end
    commit_i = 1'b0; wr_i = 1'b0;
  endtask

  function automatic logic [35:0] pair_word(input int base, input int p);
    return {18'(base + 2 * p + 1), 18'(base + 2 * p)};
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    if ({th, twr, tup, busy, done, drop} !== 42'd0) begin
      errors++; $display("FAIL reset46: got %h required 0", {th, twr, tup, busy, done, drop});
    end
    checks++;
    if ({th45, twr45, tup45, busy45, done45, drop45} !== 42'd0) begin
      errors++; $display("FAIL reset45: got %h required 0", {th45, twr45, tup45, busy45, done45});
    end
    checks++;
  endtask

  task automatic test_default_commit();
    capture(30, 2'b01, -1, 2'b00, -1);
    for (int i = 1; i <= 30; i++) begin
      if (cap_wr[i] !== ((i <= 23) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL dflt_wr[%0d]: got %b", i, cap_wr[i]);
      end
      checks++;
      if (cap_up[i] !== ((i == 26) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL dflt_up[%0d]: got %b", i, cap_up[i]);
      end
      checks++;
      if (cap_done[i] !== (i == 27)) begin
        errors++; $display("FAIL dflt_done[%0d]: got %b", i, cap_done[i]);
      end
      checks++;
      if (cap_busy[i] !== (i <= 27)) begin
        errors++; $display("FAIL dflt_busy[%0d]: got %b", i, cap_busy[i]);
      end
      checks++;
      if (i <= 23) begin
        if (cap_th[i] !== 36'hFFFFFFFFF) begin
          errors++; $display("FAIL dflt_th[%0d]: got %h required fffffffff", i, cap_th[i]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_shadow_load();
    int nup;
    for (int b = 0; b < 46; b++) wr_shadow(1'b0, b, 1000 + b);
    capture(30, 2'b01, -1, 2'b00, -1);
    for (int i = 1; i <= 23; i++) begin
      if (cap_th[i] !== pair_word(1000, 23 - i)) begin
        errors++; $display("FAIL load_th[%0d]: got %h required %h", i, cap_th[i],
                           pair_word(1000, 23 - i));
      end
      checks++;
    end
    nup = 0;
    for (int i = 1; i <= 30; i++) if (cap_up[i] != 2'b00) nup++;
    if (nup != 1 || cap_up[26] !== 2'b01) begin
      errors++; $display("FAIL load_update: got %0d strobes, cyc26=%b required 1, 01", nup,
                         cap_up[26]);
    end
    checks++;
  endtask

  task automatic test_both_sets();
    logic [1:0]  ew, eu;
    for (int b = 0; b < 46; b++) wr_shadow(1'b1, b, 2000 + b);
    capture(60, 2'b11, -1, 2'b00, -1);
    for (int i = 1; i <= 60; i++) begin
      ew = (i <= 23) ? 2'b01 : (i >= 27 && i <= 49) ? 2'b10 : 2'b00;
      eu = (i == 26) ? 2'b01 : (i == 52) ? 2'b10 : 2'b00;
      if (cap_wr[i] !== ew || cap_up[i] !== eu) begin
        errors++; $display("FAIL both_wr_up[%0d]: got %b/%b required %b/%b", i, cap_wr[i],
                           cap_up[i], ew, eu);
      end
      checks++;
      if (cap_done[i] !== (i == 53) || cap_busy[i] !== (i <= 53)) begin
        errors++; $display("FAIL both_done_busy[%0d]: got %b/%b", i, cap_done[i], cap_busy[i]);
      end
      checks++;
      if (i >= 27 && i <= 49) begin
        if (cap_th[i] !== pair_word(2000, 49 - i)) begin
          errors++; $display("FAIL both_th1[%0d]: got %h required %h", i, cap_th[i],
                             pair_word(2000, 49 - i));
        end
        checks++;
      end
    end
  endtask

  task automatic test_pending();
    logic [1:0] ew, eu;
    capture(60, 2'b01, 5, 2'b10, -1);
    for (int i = 1; i <= 60; i++) begin
      ew = (i <= 23) ? 2'b01 : (i >= 28 && i <= 50) ? 2'b10 : 2'b00;
      eu = (i == 26) ? 2'b01 : (i == 53) ? 2'b10 : 2'b00;
      if (cap_wr[i] !== ew || cap_up[i] !== eu) begin
        errors++; $display("FAIL pend_wr_up[%0d]: got %b/%b required %b/%b", i, cap_wr[i],
                           cap_up[i], ew, eu);
      end
      checks++;
      if (cap_done[i] !== (i == 27 || i == 54) || cap_busy[i] !== (i <= 54)) begin
        errors++; $display("FAIL pend_done_busy[%0d]: got %b/%b", i, cap_done[i], cap_busy[i]);
      end
      checks++;
    end
    if (cap_th[28] !== pair_word(2000, 22)) begin
      errors++; $display("FAIL pend_th: got %h required %h", cap_th[28], pair_word(2000, 22));
    end
    checks++;
  endtask

  task automatic test_write_drop();
    capture(30, 2'b01, -1, 2'b00, 3);
    if (cap_drop[3] !== 1'b0 || cap_drop[4] !== 1'b1) begin
      errors++; $display("FAIL drop_set: got %b%b required 01", cap_drop[3], cap_drop[4]);
    end
    checks++;
    tick(); tick(); tick();
    if (drop !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_sticky: got drop=%b busy=%b required 1 0", drop, busy);
    end
    checks++;
    capture(30, 2'b01, -1, 2'b00, -1);
    if (cap_drop[1] !== 1'b0) begin
      errors++; $display("FAIL drop_clear: got %b required 0", cap_drop[1]);
    end
    checks++;
    if (cap_th[23] !== pair_word(1000, 0)) begin
      errors++; $display("FAIL drop_shadow: got %h required %h", cap_th[23], pair_word(1000, 0));
    end
    checks++;
  endtask

  task automatic test_odd_reset();
    int nup;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    wr_shadow(1'b0, 44, 18'h0ABCD);
    wr_shadow(1'b0, 45, 18'h01234);
    commit_i = 1'b1; commit_mask_i = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      tick();
      commit_i = 1'b0; commit_mask_i = 2'b00;
    end
    if (twr45 !== 2'b01) begin
      errors++; $display("FAIL odd_midload: got %b required 01", twr45);
    end
    checks++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    if ({th45, twr45, tup45, busy45, done45} !== 41'd0 || {twr, tup, busy} !== 5'd0) begin
      errors++; $display("FAIL odd_rst_out: got %h %b%b%b required 0", th45, twr, tup, busy);
    end
    checks++;
    nup = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tup45 != 2'b00 || tup != 2'b00 || busy45 || busy) nup++;
    end
    if (nup != 0) begin
      errors++; $display("FAIL odd_no_update: got %0d active cycles required 0", nup);
    end
    checks++;
    wr_shadow(1'b0, 44, 18'h0ABCD);
    wr_shadow(1'b0, 45, 18'h01234);
    capture(30, 2'b01, -1, 2'b00, -1);
    if (c45_th[1] !== {18'h3FFFF, 18'h0ABCD}) begin
      errors++; $display("FAIL odd_pad: got %h required %h", c45_th[1], {18'h3FFFF, 18'h0ABCD});
    end
    checks++;
    if (cap_th[1] !== {18'h01234, 18'h0ABCD}) begin
      errors++; $display("FAIL even_top: got %h required %h", cap_th[1], {18'h01234, 18'h0ABCD});
    end
    checks++;
    if (c45_th[23] !== 36'hFFFFFFFFF || c45_wr[23] !== 2'b01 || c45_wr[24] !== 2'b00) begin
      errors++; $display("FAIL odd_tail: got %h %b %b", c45_th[23], c45_wr[23], c45_wr[24]);
    end
    checks++;
    if (c45_up[26] !== 2'b01 || c45_done[27] !== 1'b1) begin
      errors++; $display("FAIL odd_update: got %b %b required 01 1", c45_up[26], c45_done[27]);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_default_commit();
    test_shadow_load();
    test_both_sets();
    test_pending();
    test_write_drop();
    test_odd_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
